dds_cmd_dispatcher: RTL and testbench
=====================================

# dds_cmd_dispatcher

Command dispatcher between the UART receiver and the DDS/PWM channel bank. It frames the 14-byte host command packet from the received byte stream, validates it, and issues configuration-write and enable/disable strobes to the addressed channel. It also keeps the authoritative per-channel enable register. It sits downstream of `uart_rx` and upstream of the fast PWM, slow PWM and DAC channel instances in `dds_sample_top`.

## Interface
- `NUM_CH`, 3: number of addressable channels, numbered 1..NUM_CH.
- `TIMEOUT_CYC`, 50_000: maximum gap, in sys_clk cycles, allowed between bytes of one packet.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `cfg_wr`  out  1  one-cycle config-write strobe.
- `cfg_ch`  out  8  target channel, 1-based.
- `cfg_duty`  out  8  duty_num field.
- `cfg_dessert`  out  16  pulse_dessert field, {H,L}.
- `cfg_pulse_num`  out  8  pulse_num field.
- `cfg_pattern`  out  32  {pat1,pat2,pat3,pat4}.
- `ch_enable`  out  NUM_CH  per-channel enable; bit k = channel k+1.
- `pkt_ok`  out  1  one-cycle strobe when a packet executes.
- `pkt_err`  out  1  one-cycle strobe when a packet is rejected.
- `err_code`  out  3  reason for the last rejection; held until the next `pkt_ok` or `pkt_err`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Packet format, bytes 0..13: 0x55, func, ch, ctrl_sta, duty, dessert_h, dessert_l, pulse_num, pat1..pat4, chk, 0xAA.
- chk is the XOR of bytes 1..11.
- States:
  - IDLE: a byte equal to 0x55 moves to RECV with idx=1. Any other byte is dropped silently, with no error.
  - RECV: each `rx_valid` stores the byte at idx and increments idx. When the byte at idx=13 arrives, the state moves to CHECK.
  - CHECK: one cycle; computes the error.
  - EXEC: one cycle; drives the strobes, then returns to IDLE.
- Errors, highest priority first:
  - 1: footer is not 0xAA.
  - 2: checksum mismatch.
  - 3: func is not 0x01 or 0x02.
  - 4: ch is 0 or greater than NUM_CH.
  - 6: func 0x01 sent to a channel whose enable is set (reconfiguring a running channel is forbidden).
  - 5 (timeout) is raised directly from RECV.
- On any error: `pkt_err` pulses, `err_code` is updated, nothing else changes.
- func 0x01 on success: `cfg_wr` pulses and the `cfg_*` fields are driven.
- func 0x02 on success: `ch_enable[ch-1]` is set to ctrl_sta[0]. Other ctrl_sta bits are ignored.
- `cfg_*` data outputs hold their last values between strobes.
- The running checksum accumulates in RECV. The footer byte is not included.
- `rx_valid` during CHECK or EXEC is dropped. A 0x55 arriving there is not a new header.
- A second 0x55 inside RECV is treated as data, with no resync.

## Timing
- Reset values:
  - state=IDLE; `cfg_wr`, `pkt_ok`, `pkt_err`, `busy` = 0.
  - `cfg_*` data = 0.
  - `ch_enable` = 0; `err_code` = 0.
- The footer byte is accepted in cycle N. CHECK runs in N+1. `cfg_wr`, `pkt_ok` or `pkt_err`, and any `ch_enable` change take effect in cycle N+2.
- Latency from footer to effect is fixed at 2 cycles.
- Reset asserted mid-packet forces all reset values immediately. A partial packet is discarded.
- Timeout: TIMEOUT_CYC consecutive cycles in RECV with no `rx_valid` cause:
  - `pkt_err` in the next cycle, with `err_code`=5;
  - return to IDLE.
- The timeout counter clears on every `rx_valid`.

## Configuration
- `DDS_CMD_TIMEOUT_EN` defined: the inter-byte timeout is active, and `err_code` 5 is reachable.
- Without it: no counter is synthesised, and RECV waits indefinitely for the rest of the packet.

## Structure
- Shared package `dds_cmd_pkg` holds:
  - HDR=8'h55, FTR=8'hAA, PKT_LEN=14;
  - FUNC_CFG=8'h01, FUNC_EN=8'h02;
  - a `typedef enum` of the error codes;
  - a `typedef enum` of the state machine states.
- No sub-module. Byte capture, XOR accumulation and the timeout counter are all inline.

## Test plan
- 55 01 02 00 01 00 01 00 00 00 00 01 02 AA -> `cfg_wr` pulses with:
  - `cfg_ch`=2, `cfg_duty`=1, `cfg_dessert`=16'h0001;
  - `cfg_pattern`=32'h00000001;
  - `pkt_ok` asserted 2 cycles after the footer byte.
- 55 02 01 01 00×8 02 AA -> `ch_enable`=3'b001. A following config packet to ch1 (chk 03) -> `pkt_err` with `err_code`=6 and no `cfg_wr`.
- Disable ch1 with chk 0x55 -> `pkt_err` with `err_code`=2 and `ch_enable` unchanged. Resending with chk 0x03 -> `ch_enable`=3'b000.
- Inputs of 0x12, 0x34 sent before a valid packet are silently skipped. A packet with ch=0x04 -> `err_code`=4. A packet with footer 0xAB -> `err_code`=1.
- With `DDS_CMD_TIMEOUT_EN`, send 5 bytes and then idle TIMEOUT_CYC cycles -> `pkt_err`, `err_code`=5, `busy`=0. The next full packet then succeeds.
- Assert `sys_rst_n` low for one cycle after byte 7 -> all outputs return to reset values. A complete packet sent afterwards executes normally.

Source files
------------

// File: rtl/dds_cmd_pkg.sv
// Shared constants and types for the host command dispatcher: packet framing
// bytes, function codes, rejection codes and dispatcher states.
package dds_cmd_pkg;

  localparam logic [7:0] HDR      = 8'h55;
  localparam logic [7:0] FTR      = 8'hAA;
  localparam int         PKT_LEN  = 14;

  localparam logic [7:0] FUNC_CFG = 8'h01;
  localparam logic [7:0] FUNC_EN  = 8'h02;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_FOOTER  = 3'd1,
    ERR_CHKSUM  = 3'd2,
    ERR_FUNC    = 3'd3,
    ERR_CHAN    = 3'd4,
    ERR_TIMEOUT = 3'd5,
    ERR_RUNNING = 3'd6
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_EXEC
  } state_e;

endpackage

// File: rtl/dds_cmd_dispatcher.sv
// Frames 14-byte host packets from the UART byte stream, validates them and drives
// channel config/enable strobes. Define DDS_CMD_TIMEOUT_EN for the inter-byte timeout.
module dds_cmd_dispatcher
  import dds_cmd_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              cfg_wr,
  output logic [7:0]        cfg_ch,
  output logic [7:0]        cfg_duty,
  output logic [15:0]       cfg_dessert,
  output logic [7:0]        cfg_pulse_num,
  output logic [31:0]       cfg_pattern,
  output logic [NUM_CH-1:0] ch_enable,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [2:0]        err_code,
  output logic              busy
);

  state_e             state_q;
  logic [3:0]         idx_q;
  logic [7:0]         func_q, ch_q, chk_q, ftr_q, xor_q;
  logic               ctrl_q;
  logic [7:0]         duty_q, pnum_q;
  logic [15:0]        des_q;
  logic [31:0]        pat_q;

  logic               cfg_wr_q, pkt_ok_q, pkt_err_q;
  logic [7:0]         cfg_ch_q, cfg_duty_q, cfg_pnum_q;
  logic [15:0]        cfg_des_q;
  logic [31:0]        cfg_pat_q;
  logic [NUM_CH-1:0]  ch_en_q;
  err_e               err_q;

  err_e               err_d;
  logic [NUM_CH-1:0]  ch_en_d;
  logic               ch_ok, ch_on;

`ifdef DDS_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // Validation of the captured packet, evaluated while in CHECK.
  always_comb begin
    ch_ok   = 1'b0;
    ch_on   = 1'b0;
    ch_en_d = ch_en_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 8'(k + 1)) begin
        ch_ok      = 1'b1;
        ch_on      = ch_en_q[k];
        ch_en_d[k] = ctrl_q;
      end
    end
    err_d = ERR_NONE;
    if (ftr_q != FTR)                                err_d = ERR_FOOTER;
    else if (xor_q != chk_q)                         err_d = ERR_CHKSUM;
    else if (func_q != FUNC_CFG && func_q != FUNC_EN) err_d = ERR_FUNC;
    else if (!ch_ok)                                 err_d = ERR_CHAN;
    else if (func_q == FUNC_CFG && ch_on)            err_d = ERR_RUNNING;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      func_q     <= '0;
      ch_q       <= '0;
      chk_q      <= '0;
      ftr_q      <= '0;
      xor_q      <= '0;
      ctrl_q     <= 1'b0;
      duty_q     <= '0;
      pnum_q     <= '0;
      des_q      <= '0;
      pat_q      <= '0;
      cfg_wr_q   <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      cfg_ch_q   <= '0;
      cfg_duty_q <= '0;
      cfg_pnum_q <= '0;
      cfg_des_q  <= '0;
      cfg_pat_q  <= '0;
      ch_en_q    <= '0;
      err_q      <= ERR_NONE;
`ifdef DDS_CMD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      cfg_wr_q  <= 1'b0;
      pkt_ok_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == HDR) begin
            state_q <= ST_RECV;
            idx_q   <= 4'd1;
            xor_q   <= '0;
`ifdef DDS_CMD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_RECV: begin
          if (rx_valid) begin
            case (idx_q)
              4'd1:    func_q        <= rx_data;
              4'd2:    ch_q          <= rx_data;
              4'd3:    ctrl_q        <= rx_data[0];
              4'd4:    duty_q        <= rx_data;
              4'd5:    des_q[15:8]   <= rx_data;
              4'd6:    des_q[7:0]    <= rx_data;
              4'd7:    pnum_q        <= rx_data;
              4'd8:    pat_q[31:24]  <= rx_data;
              4'd9:    pat_q[23:16]  <= rx_data;
              4'd10:   pat_q[15:8]   <= rx_data;
              4'd11:   pat_q[7:0]    <= rx_data;
              4'd12:   chk_q         <= rx_data;
              default: ftr_q         <= rx_data;
            endcase
            // Checksum covers func..pat4 only; chk and footer are excluded.
            if (idx_q <= 4'd11) xor_q <= xor_q ^ rx_data;
            if (idx_q == 4'(PKT_LEN - 1)) state_q <= ST_CHECK;
            idx_q <= idx_q + 4'd1;
`ifdef DDS_CMD_TIMEOUT_EN
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            pkt_err_q <= 1'b1;
            err_q     <= ERR_TIMEOUT;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        ST_CHECK: begin
          state_q <= ST_EXEC;
          if (err_d != ERR_NONE) begin
            pkt_err_q <= 1'b1;
            err_q     <= err_d;
          end else begin
            pkt_ok_q <= 1'b1;
            err_q    <= ERR_NONE;
            if (func_q == FUNC_CFG) begin
              cfg_wr_q   <= 1'b1;
              cfg_ch_q   <= ch_q;
              cfg_duty_q <= duty_q;
              cfg_des_q  <= des_q;
              cfg_pnum_q <= pnum_q;
              cfg_pat_q  <= pat_q;
            end else begin
              ch_en_q <= ch_en_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_wr        = cfg_wr_q;
  assign cfg_ch        = cfg_ch_q;
  assign cfg_duty      = cfg_duty_q;
  assign cfg_dessert   = cfg_des_q;
  assign cfg_pulse_num = cfg_pnum_q;
  assign cfg_pattern   = cfg_pat_q;
  assign ch_enable     = ch_en_q;
  assign pkt_ok        = pkt_ok_q;
  assign pkt_err       = pkt_err_q;
  assign err_code      = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_cmd_dispatcher.sv
// Directed bench for dds_cmd_dispatcher: a packet model pushes expected outcomes to a
// scoreboard queue, and a monitor pops and compares them when the DUT strobes.
module tb_dds_cmd_dispatcher;

  localparam int TMO = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cfg_wr;
  logic [7:0]  cfg_ch, cfg_duty, cfg_pulse_num;
  logic [15:0] cfg_dessert;
  logic [31:0] cfg_pattern;
  logic [2:0]  ch_enable;
  logic        pkt_ok, pkt_err;
  logic [2:0]  err_code;
  logic        busy;

  dds_cmd_dispatcher #(.NUM_CH(3), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty), .cfg_dessert(cfg_dessert),
    .cfg_pulse_num(cfg_pulse_num), .cfg_pattern(cfg_pattern), .ch_enable(ch_enable),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        ok;
    logic [2:0]  code;
    logic        wr;
    logic [7:0]  ch, duty, pn;
    logic [15:0] des;
    logic [31:0] pat;
    logic [2:0]  en;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int drive_cyc = 0;

  // Reference model state
  logic [2:0]  m_en;
  logic [7:0]  m_ch, m_duty, m_pn;
  logic [15:0] m_des;
  logic [31:0] m_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk_exp(input int c, input logic ok, input logic [2:0] code,
                                  input logic wr);
    exp_t e;
    e.cyc = c; e.ok = ok; e.code = code; e.wr = wr;
    e.ch = m_ch; e.duty = m_duty; e.pn = m_pn; e.des = m_des; e.pat = m_pat; e.en = m_en;
    return e;
  endfunction

  always @(negedge sys_clk) begin
    if (sys_rst_n && (pkt_ok || pkt_err || cfg_wr)) begin
      if (q.size() == 0) begin
        chk("spurious_strobe", {29'd0, cfg_wr, pkt_err, pkt_ok}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency",     cyc,          e.cyc);
        chk("pkt_ok",      pkt_ok,       e.ok);
        chk("pkt_err",     pkt_err,      !e.ok);
        chk("err_code",    err_code,     e.code);
        chk("cfg_wr",      cfg_wr,       e.wr);
        chk("cfg_ch",      cfg_ch,       e.ch);
        chk("cfg_duty",    cfg_duty,     e.duty);
        chk("cfg_dessert", cfg_dessert,  e.des);
        chk("cfg_pulse",   cfg_pulse_num, e.pn);
        chk("cfg_pattern", cfg_pattern,  e.pat);
        chk("ch_enable",   ch_enable,    e.en);
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_valid  = 1'b1;
    drive_cyc = cyc;
    @(posedge sys_clk);
    #1;
    rx_valid  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] func, input logic [7:0] ch, input logic [7:0] ctrl,
                          input logic [7:0] duty, input logic [15:0] des, input logic [7:0] pn,
                          input logic [31:0] pat, input int chk_ovr = -1,
                          input logic [7:0] ftr = 8'hAA);
    logic [7:0] b [14];
    logic [7:0] x;
    logic [2:0] code;
    logic       wr;
    b = '{8'h55, func, ch, ctrl, duty, des[15:8], des[7:0], pn,
          pat[31:24], pat[23:16], pat[15:8], pat[7:0], 8'h00, ftr};
    x = 8'h00;
    for (int i = 1; i <= 11; i++) x = x ^ b[i];
    b[12] = (chk_ovr < 0) ? x : chk_ovr[7:0];
    code = 3'd0;
    wr   = 1'b0;
    if (ftr != 8'hAA)                          code = 3'd1;
    else if (b[12] != x)                       code = 3'd2;
    else if (func != 8'h01 && func != 8'h02)   code = 3'd3;
    else if (ch == 8'd0 || ch > 8'd3)          code = 3'd4;
    else if (func == 8'h01 && m_en[ch - 8'd1]) code = 3'd6;
    if (code == 3'd0) begin
      if (func == 8'h01) begin
        wr = 1'b1;
        m_ch = ch; m_duty = duty; m_des = des; m_pn = pn; m_pat = pat;
      end else begin
        m_en[ch - 8'd1] = ctrl[0];
      end
    end
    for (int i = 0; i < 14; i++) send_byte(b[i]);
    q.push_back(mk_exp(drive_cyc + 2, code == 3'd0, code, wr));
  endtask

  task automatic model_reset();
    m_en = '0; m_ch = '0; m_duty = '0; m_pn = '0; m_des = '0; m_pat = '0;
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    busy,        1'b0);
    chk({tag, "_cfg_wr"},  cfg_wr,      1'b0);
    chk({tag, "_pkt_ok"},  pkt_ok,      1'b0);
    chk({tag, "_pkt_err"}, pkt_err,     1'b0);
    chk({tag, "_en"},      ch_enable,   3'b000);
    chk({tag, "_err"},     err_code,    3'd0);
    chk({tag, "_ch"},      cfg_ch,      8'd0);
    chk({tag, "_duty"},    cfg_duty,    8'd0);
    chk({tag, "_des"},     cfg_dessert, 16'd0);
    chk({tag, "_pn"},      cfg_pulse_num, 8'd0);
    chk({tag, "_pat"},     cfg_pattern, 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
    gap(1);

    // Config write to channel 2
    send_pkt(8'h01, 8'h02, 8'h00, 8'h01, 16'h0001, 8'h00, 32'h0000_0001);
    gap(4);
    chk("err_after_ok", err_code, 3'd0);

    // Enable ch1, then reconfiguring it is rejected
    send_pkt(8'h02, 8'h01, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0);
    gap(4);
    send_pkt(8'h01, 8'h01, 8'h00, 8'h03, 16'h0000, 8'h00, 32'h0);
    gap(4);
    chk("err6_held", err_code, 3'd6);

    // Bad checksum disable, then a good one
    send_pkt(8'h02, 8'h01, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0, 8'h55);
    gap(4);
    send_pkt(8'h02, 8'h01, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0);
    gap(4);

    // Junk before a header is dropped silently
    send_byte(8'h12);
    send_byte(8'h34);
    gap(2);
    chk("junk_busy", busy, 1'b0);
    send_pkt(8'h02, 8'h03, 8'hFF, 8'h00, 16'h0000, 8'h00, 32'h0);
    gap(4);
    send_pkt(8'h02, 8'h04, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0);
    gap(4);
    send_pkt(8'h02, 8'h02, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0, -1, 8'hAB);
    gap(4);
    send_pkt(8'h07, 8'h02, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0);
    gap(4);

    // 0x55 as data inside RECV; stray 0x55 during CHECK/EXEC must not start a packet
    send_pkt(8'h01, 8'h02, 8'h00, 8'h55, 16'hBEEF, 8'h55, 32'h1234_5678);
    send_byte(8'h55);
    send_byte(8'h55);
    gap(3);
    chk("stray_hdr_busy", busy, 1'b0);
    send_pkt(8'h02, 8'h02, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0);
    gap(4);

`ifdef DDS_CMD_TIMEOUT_EN
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    q.push_back(mk_exp(drive_cyc + TMO + 1, 1'b0, 3'd5, 1'b0));
    gap(TMO + 6);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_err",  err_code, 3'd5);
    send_pkt(8'h01, 8'h01, 8'h00, 8'h22, 16'h0102, 8'h07, 32'hA5A5_0F0F, -1);
    gap(4);
`else
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    gap(TMO + 6);
    chk("no_timeout_busy", busy, 1'b1);
    sys_rst_n = 1'b0;
    gap(1);
    model_reset();
    sys_rst_n = 1'b1;
    gap(1);
    send_pkt(8'h02, 8'h03, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0);
    send_pkt(8'h01, 8'h01, 8'h00, 8'h22, 16'h0102, 8'h07, 32'hA5A5_0F0F);
    gap(4);
`endif

    // Reset mid-packet, after byte 7
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h09);
    send_byte(8'h00);
    send_byte(8'h03);
    chk("pre_rst_busy", busy, 1'b1);
    sys_rst_n = 1'b0;
    #2;
    check_reset_outputs("async_rst");
    model_reset();
    gap(1);
    sys_rst_n = 1'b1;
    gap(1);
    send_pkt(8'h01, 8'h03, 8'h00, 8'h40, 16'h1234, 8'h10, 32'hDEAD_BEEF);
    gap(4);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
